// File: rtl/fmu.sv
// Flag management unit: stores the ALU condition flags and evaluates the
// jump-if-true / jump-if-false condition for the selected flag.
module fmu #(
  parameter int unsigned FLAG_W = 6,
  parameter int unsigned CODE_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] flag_code,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              write_enable,
  input  logic              sel_jt_jf,
  output logic              jt_jf_ok
);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic              sel_flag;
  logic              in_range;

  always_comb begin
    flags_d = flags_q;
    if (write_enable) flags_d = flags_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  // Compare-based mux so out-of-range codes never index past the register.
  always_comb begin
    sel_flag = 1'b0;
    in_range = 1'b0;
    for (int unsigned i = 0; i < FLAG_W; i++) begin
      if (flag_code == CODE_W'(i)) begin
        sel_flag = flags_q[i];
        in_range = 1'b1;
      end
    end
    jt_jf_ok = in_range & (sel_jt_jf ? sel_flag : ~sel_flag);
  end

endmodule

// File: tb/tb_fmu.sv
// Directed self-checking bench for fmu using an expected-value queue.
module tb_fmu;

  localparam int unsigned FLAG_W = 6;
  localparam int unsigned CODE_W = 5;

  logic              clk;
  logic              rst;
  logic [CODE_W-1:0] flag_code;
  logic [FLAG_W-1:0] flags_in;
  logic              write_enable;
  logic              sel_jt_jf;
  logic              jt_jf_ok;

  logic [FLAG_W-1:0] model;
  logic              exp_q[$];
  int                n_pass;
  int                n_total;

  fmu #(.FLAG_W(FLAG_W), .CODE_W(CODE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flag_code    (flag_code),
    .flags_in     (flags_in),
    .write_enable (write_enable),
    .sel_jt_jf    (sel_jt_jf),
    .jt_jf_ok     (jt_jf_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_ok(input logic [FLAG_W-1:0] m,
                                    input logic [CODE_W-1:0] code,
                                    input logic sel);
    int c;
    c = int'(code);
    if (c >= int'(FLAG_W)) return 1'b0;
    return sel ? m[c] : ~m[c];
  endfunction

  // sync=1: move to the low clock phase first; sync=0: read right now.
  task automatic read_chk(input logic [CODE_W-1:0] code, input logic sel,
                          input bit sync, input string tag);
    logic exp;
    if (sync) @(negedge clk);
    flag_code = code;
    sel_jt_jf = sel;
    exp_q.push_back(model_ok(model, code, sel));
    #1;
    exp = exp_q.pop_front();
    n_total++;
    assert (jt_jf_ok === exp) n_pass++;
    else $error("FAIL %s code=%0d sel=%0b: got %b expected %b",
                tag, code, sel, jt_jf_ok, exp);
  endtask

  task automatic write_flags(input logic [FLAG_W-1:0] v);
    @(negedge clk);
    flags_in     = v;
    write_enable = 1'b1;
    @(posedge clk);
    model = v;
    #1;
    write_enable = 1'b0;
  endtask

  task automatic sweep(input logic sel, input string tag);
    for (int c = 0; c < int'(FLAG_W); c++)
      read_chk(CODE_W'(c), sel, 1'b1, tag);
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst          = 1'b1;
    model        = '0;
    flag_code    = '0;
    flags_in     = '1;
    write_enable = 1'b1;
    sel_jt_jf    = 1'b1;

    // Reset holds flags at zero even with write_enable asserted.
    repeat (2) @(posedge clk);
    sweep(1'b1, "reset_jt");
    sweep(1'b0, "reset_jf");
    read_chk(5'd6, 1'b0, 1'b1, "reset_oor");
    @(negedge clk);
    write_enable = 1'b0;
    rst          = 1'b0;

    write_flags(6'b111111);
    sweep(1'b1, "ones_jt");
    sweep(1'b0, "ones_jf");

    foreach (exp_q[i]) $error("FAIL queue_leftover: got %0d entries expected 0", exp_q.size());
    read_chk(5'd6,  1'b1, 1'b1, "oor6_jt");
    read_chk(5'd6,  1'b0, 1'b1, "oor6_jf");
    read_chk(5'd7,  1'b1, 1'b1, "oor7_jt");
    read_chk(5'd7,  1'b0, 1'b1, "oor7_jf");
    read_chk(5'd31, 1'b1, 1'b1, "oor31_jt");
    read_chk(5'd31, 1'b0, 1'b1, "oor31_jf");

    write_flags(6'b000100);
    sweep(1'b1, "walk_jt");
    sweep(1'b0, "walk_jf");

    write_flags(6'b101010);
    @(negedge clk);
    flags_in     = 6'b010101;
    write_enable = 1'b0;
    repeat (3) @(posedge clk);
    read_chk(5'd1, 1'b1, 1'b1, "hold_c1");
    read_chk(5'd0, 1'b1, 1'b1, "hold_c0");
    sweep(1'b1, "hold_jt");

    // Same-cycle write/read: old value before the edge, new value after.
    @(negedge clk);
    flags_in     = 6'b010101;
    write_enable = 1'b1;
    read_chk(5'd0, 1'b1, 1'b0, "rw_before");
    read_chk(5'd1, 1'b1, 1'b0, "rw_before_c1");
    @(posedge clk);
    model = 6'b010101;
    #1;
    write_enable = 1'b0;
    read_chk(5'd0, 1'b1, 1'b0, "rw_after");
    read_chk(5'd1, 1'b1, 1'b0, "rw_after_c1");

    // Asynchronous reset between edges while a write is requested.
    write_flags(6'b111111);
    read_chk(5'd0, 1'b1, 1'b1, "pre_async");
    flags_in     = 6'b111111;
    write_enable = 1'b1;
    #1;
    rst   = 1'b1;
    model = '0;
    read_chk(5'd0, 1'b1, 1'b0, "async_drop");
    read_chk(5'd3, 1'b0, 1'b0, "async_jf");
    @(posedge clk);
    #1;
    read_chk(5'd0, 1'b1, 1'b0, "rst_over_we");

    // First write after reset release lands on the first enabled edge.
    @(negedge clk);
    rst = 1'b0;
    read_chk(5'd0, 1'b1, 1'b0, "post_rst_pre");
    @(posedge clk);
    model = 6'b111111;
    #1;
    write_enable = 1'b0;
    read_chk(5'd0, 1'b1, 1'b0, "post_rst_write");
    read_chk(5'd5, 1'b0, 1'b0, "post_rst_jf");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
